// File: rtl/comparison_scan_ctrl.sv
// Frame scanner: finds the first masked-in magnitude above a snapshotted cutoff, one sample per cycle.
// Verdict appears 2+k cycles after accept (N+1 on no hit); verdict is held until send_rdy and no new frame is accepted meanwhile.
module comparison_scan_ctrl #(
    parameter int BIT_WIDTH  = 32,
    parameter int N_SAMPLES  = 8,
    parameter int CUTOFF_MAG = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_val,
    input  logic [BIT_WIDTH-1:0]          cfg_cutoff,
    input  logic                          recv_val,
    output logic                          recv_rdy,
    input  logic [BIT_WIDTH-1:0]          recv_mag [N_SAMPLES],
    input  logic [N_SAMPLES-1:0]          recv_mask,
    output logic                          send_val,
    input  logic                          send_rdy,
    output logic                          send_hit,
    output logic [$clog2(N_SAMPLES)-1:0]  send_idx,
    output logic                          busy
);

    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [BIT_WIDTH-1:0]   r_cutoff;
    logic [BIT_WIDTH-1:0]   r_snap;
    logic [BIT_WIDTH-1:0]   r_mag [N_SAMPLES];
    logic [N_SAMPLES-1:0]   r_mask;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_hit;
    logic [IDX_W-1:0]       r_send_idx;

    logic                   w_accept;
    logic                   w_sample_hit;
    logic                   w_last;

    assign recv_rdy = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign send_val = (r_state == SEND);
    assign send_hit = r_hit;
    assign send_idx = r_send_idx;

    assign w_accept     = recv_val && recv_rdy;
    assign w_sample_hit = r_mask[r_idx] && (r_mag[r_idx] > r_snap);
    assign w_last       = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_sample_hit || w_last) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (send_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Cutoff writes are accepted in every state; a frame in flight keeps its own snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cutoff <= BIT_WIDTH'(CUTOFF_MAG);
        end else if (cfg_val) begin
            r_cutoff <= cfg_cutoff;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap <= '0;
            r_mask <= '0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                r_mag[i] <= '0;
            end
        end else if (r_state == IDLE && w_accept) begin
            r_snap <= r_cutoff;
            r_mask <= recv_mask;
            for (int i = 0; i < N_SAMPLES; i++) begin
                r_mag[i] <= recv_mag[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= '0;
            r_hit      <= 1'b0;
            r_send_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx <= '0;
                    end
                end
                SCAN: begin
                    if (w_sample_hit) begin
                        r_hit      <= 1'b1;
                        r_send_idx <= r_idx;
                    end else if (w_last) begin
                        r_hit      <= 1'b0;
                        r_send_idx <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparison_scan_ctrl.sv
// Directed bench for comparison_scan_ctrl with N_SAMPLES=8, cutoff reset value 20.
module tb_comparison_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_val;
    logic [31:0] cfg_cutoff;
    logic        recv_val;
    logic        recv_rdy;
    logic [31:0] mag [8];
    logic [7:0]  mask;
    logic        send_val;
    logic        send_rdy;
    logic        send_hit;
    logic [2:0]  send_idx;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    comparison_scan_ctrl #(
        .BIT_WIDTH (32),
        .N_SAMPLES (8),
        .CUTOFF_MAG(20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_val   (cfg_val),
        .cfg_cutoff(cfg_cutoff),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .recv_mag  (mag),
        .recv_mask (mask),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .send_hit  (send_hit),
        .send_idx  (send_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 8; i++) mag[i] = v;
    endtask

    // Accept a frame at the next edge, wait for the verdict, optionally stall, then complete the handshake.
    task automatic run_frame(input string tag, input logic exp_hit, input logic [2:0] exp_idx,
                             input int exp_lat, input int hold);
        int cyc;
        chk({tag, "_rdy_before"}, 32'(recv_rdy), 32'd1);
        recv_val = 1'b1;
        step();
        recv_val = 1'b0;
        cfg_val  = 1'b0;
        fill(32'hFFFF_FFFF);
        mask = 8'hFF;
        cyc = 1;
        while (!send_val && cyc < 40) begin
            step();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_hit"}, 32'(send_hit), 32'(exp_hit));
        chk({tag, "_idx"}, 32'(send_idx), 32'(exp_idx));
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_hold_val"}, 32'(send_val), 32'd1);
            chk({tag, "_hold_hit"}, 32'(send_hit), 32'(exp_hit));
            chk({tag, "_hold_idx"}, 32'(send_idx), 32'(exp_idx));
            chk({tag, "_hold_rdy"}, 32'(recv_rdy), 32'd0);
        end
        send_rdy = 1'b1;
        step();
        send_rdy = 1'b0;
        chk({tag, "_done_val"}, 32'(send_val), 32'd0);
        chk({tag, "_done_rdy"}, 32'(recv_rdy), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        cfg_val    = 1'b0;
        cfg_cutoff = '0;
        recv_val   = 1'b0;
        send_rdy   = 1'b0;
        mask       = '0;
        fill(32'd0);
        step();
        step();
        chk("rst_send_val", 32'(send_val), 32'd0);
        chk("rst_send_hit", 32'(send_hit), 32'd0);
        chk("rst_send_idx", 32'(send_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_recv_rdy", 32'(recv_rdy), 32'd1);
        reset = 1'b0;
        step();

        // 1: nothing above cutoff -> full scan
        fill(32'd10); mask = 8'hFF;
        run_frame("t1", 1'b0, 3'd0, 9, 0);

        // 2: first hit at 3
        fill(32'd10); mag[3] = 32'd21; mask = 8'hFF;
        run_frame("t2", 1'b1, 3'd3, 5, 0);

        // 3: masked-out 50 at 2, equal-to-cutoff at 4, hit at 6
        fill(32'd10); mag[2] = 32'd50; mag[4] = 32'd20; mag[6] = 32'd21; mask = 8'hFB;
        run_frame("t3", 1'b1, 3'd6, 8, 0);

        // 3b: all-zero mask never hits
        fill(32'd1000); mask = 8'h00;
        run_frame("t3b", 1'b0, 3'd0, 9, 0);

        // 4: cutoff write coincides with accept -> old cutoff applies to this frame
        fill(32'd10); mag[1] = 32'd50; mask = 8'hFF;
        cfg_val = 1'b1; cfg_cutoff = 32'd100;
        run_frame("t4a", 1'b1, 3'd1, 3, 0);
        fill(32'd10); mag[1] = 32'd50; mag[5] = 32'd101; mask = 8'hFF;
        run_frame("t4b", 1'b1, 3'd5, 7, 0);

        // 5: restore cutoff 20, hit at 0 with stalled verdict
        cfg_val = 1'b1; cfg_cutoff = 32'd20;
        step();
        cfg_val = 1'b0;
        fill(32'd10); mag[0] = 32'd21; mask = 8'hFF;
        run_frame("t5", 1'b1, 3'd0, 2, 4);

        // 6: raise cutoff, then reset in the middle of a scan
        cfg_val = 1'b1; cfg_cutoff = 32'd100;
        step();
        cfg_val = 1'b0;
        fill(32'd10); mask = 8'hFF;
        recv_val = 1'b1;
        step();
        recv_val = 1'b0;
        step(); step(); step(); step();
        chk("t6_busy_scan", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_send_val", 32'(send_val), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_recv_rdy", 32'(recv_rdy), 32'd1);
        step();
        reset = 1'b0;
        step();
        chk("t6_no_verdict", 32'(send_val), 32'd0);
        fill(32'd10); mag[0] = 32'd21; mask = 8'hFF;
        run_frame("t6", 1'b1, 3'd0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
